// File: rtl/mem1port_arbiter_if.sv
// rtl/mem1port_arbiter_if.sv - requester and SRAM port bundle for the single-port memory arbiter
interface mem1port_arbiter_if;
  // instruction fetch port
  logic        i_valid;
  logic [29:0] i_addr;
  logic        i_gnt;
  logic        i_rresp;
  logic [31:0] i_rdata;
  // data read port
  logic        d_rvalid;
  logic [29:0] d_raddr;
  logic        d_rgnt;
  logic        d_rresp;
  logic [31:0] d_rdata;
  // data write port
  logic        d_wvalid;
  logic [29:0] d_waddr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_wgnt;
  // SRAM port
  logic        m_ready;
  logic        m_we;
  logic [29:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_rresp;
  logic [31:0] m_rdata;
  // status
  logic        wb_full;

  // arbiter side
  modport slave (
    input  i_valid, i_addr, d_rvalid, d_raddr,
    input  d_wvalid, d_waddr, d_wdata, d_wstrb,
    input  m_rresp, m_rdata,
    output i_gnt, i_rresp, i_rdata, d_rgnt, d_rresp, d_rdata, d_wgnt,
    output m_ready, m_we, m_addr, m_wdata, m_wstrb, wb_full
  );

  // requesters plus SRAM side
  modport master (
    output i_valid, i_addr, d_rvalid, d_raddr,
    output d_wvalid, d_waddr, d_wdata, d_wstrb,
    output m_rresp, m_rdata,
    input  i_gnt, i_rresp, i_rdata, d_rgnt, d_rresp, d_rdata, d_wgnt,
    input  m_ready, m_we, m_addr, m_wdata, m_wstrb, wb_full
  );
endinterface

// File: rtl/mem1port_arbiter.sv
// rtl/mem1port_arbiter.sv - shares one single-port SRAM between instruction fetch, data reads and a posted write buffer
module mem1port_arbiter #(
  parameter int IFETCH_MAXWAIT = 4
) (
  input  logic                clk,
  input  logic                resetb,
  mem1port_arbiter_if.slave   bus
);

  localparam int CW = $clog2(IFETCH_MAXWAIT + 1);
  localparam logic [CW-1:0] ICNT_MAX = CW'(IFETCH_MAXWAIT);

  typedef enum logic [1:0] {SEL_IDLE, SEL_IF, SEL_DR, SEL_DRAIN} sel_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DR} owner_e;

  // registered state
  logic          wb_valid;
  logic [29:0]   wb_addr;
  logic [31:0]   wb_data;
  logic [3:0]    wb_strb;
  owner_e        owner;
  logic [CW-1:0] icnt;

  // next-state values
  logic          wb_valid_nxt;
  logic [29:0]   wb_addr_nxt;
  logic [31:0]   wb_data_nxt;
  logic [3:0]    wb_strb_nxt;
  owner_e        owner_nxt;
  logic [CW-1:0] icnt_nxt;

  sel_e sel;
  logic hit;
  logic wgnt;

  // Pick this cycle's memory operation; a same-word read behind the buffer forces the drain first
  always_comb begin
    hit = wb_valid && bus.d_rvalid && (bus.d_raddr == wb_addr);
    if (hit)
      sel = SEL_DRAIN;
    else if (bus.i_valid && (icnt == ICNT_MAX))
      sel = SEL_IF;
    else if (bus.d_rvalid)
      sel = SEL_DR;
    else if (wb_valid && bus.d_wvalid)
      sel = SEL_DRAIN;
    else if (bus.i_valid)
      sel = SEL_IF;
    else if (wb_valid)
      sel = SEL_DRAIN;
    else
      sel = SEL_IDLE;
  end

  // Drive the SRAM port and grants from the selection and compute the next register values
  always_comb begin
    bus.i_gnt   = 1'b0;
    bus.d_rgnt  = 1'b0;
    bus.m_ready = 1'b0;
    bus.m_we    = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.m_wstrb = '0;
    owner_nxt   = OWN_NONE;

    case (sel)
      SEL_IF: begin
        bus.m_ready = 1'b1;
        bus.m_addr  = bus.i_addr;
        bus.i_gnt   = 1'b1;
        owner_nxt   = OWN_IF;
      end
      SEL_DR: begin
        bus.m_ready = 1'b1;
        bus.m_addr  = bus.d_raddr;
        bus.d_rgnt  = 1'b1;
        owner_nxt   = OWN_DR;
      end
      SEL_DRAIN: begin
        bus.m_ready = 1'b1;
        bus.m_we    = 1'b1;
        bus.m_addr  = wb_addr;
        bus.m_wdata = wb_data;
        bus.m_wstrb = wb_strb;
      end
      default: ;
    endcase

    // the buffer accepts a write when empty or when it is being emptied this cycle
    wgnt       = bus.d_wvalid && (!wb_valid || (sel == SEL_DRAIN));
    bus.d_wgnt = wgnt;

    wb_valid_nxt = wb_valid && (sel != SEL_DRAIN);
    wb_addr_nxt  = wb_addr;
    wb_data_nxt  = wb_data;
    wb_strb_nxt  = wb_strb;
    if (wgnt) begin
      wb_valid_nxt = 1'b1;
      wb_addr_nxt  = bus.d_waddr;
      wb_data_nxt  = bus.d_wdata;
      wb_strb_nxt  = bus.d_wstrb;
    end

    if (!bus.i_valid || (sel == SEL_IF))
      icnt_nxt = '0;
    else if (icnt != ICNT_MAX)
      icnt_nxt = icnt + CW'(1);
    else
      icnt_nxt = icnt;
  end

  // State registers; reset drops any in-flight response and the buffered write
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      wb_strb  <= '0;
      owner    <= OWN_NONE;
      icnt     <= '0;
    end else begin
      wb_valid <= wb_valid_nxt;
      wb_addr  <= wb_addr_nxt;
      wb_data  <= wb_data_nxt;
      wb_strb  <= wb_strb_nxt;
      owner    <= owner_nxt;
      icnt     <= icnt_nxt;
    end
  end

  // read data is shared; only the valid flags are steered to the owner
  assign bus.i_rresp = bus.m_rresp && (owner == OWN_IF);
  assign bus.d_rresp = bus.m_rresp && (owner == OWN_DR);
  assign bus.i_rdata = bus.m_rdata;
  assign bus.d_rdata = bus.m_rdata;
  assign bus.wb_full = wb_valid;

endmodule

// File: tb/tb_mem1port_arbiter.sv
// tb/tb_mem1port_arbiter.sv - self-checking bench for mem1port_arbiter
module tb_mem1port_arbiter;

  localparam int MAXW = 4;

  logic clk = 1'b0;
  logic resetb = 1'b0;
  logic preload = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mem1port_arbiter_if bus();

  mem1port_arbiter #(.IFETCH_MAXWAIT(MAXW)) dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus.slave)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 16) return 32'hDEADBEEF;
    return {16'hC0DE, 8'h5A, 8'(i)};
  endfunction

  // SRAM model: one-cycle read latency, byte-strobed writes
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      bus.m_rresp <= 1'b0;
      bus.m_rdata <= '0;
    end else begin
      bus.m_rresp <= bus.m_ready && !bus.m_we;
      bus.m_rdata <= mem[bus.m_addr[7:0]];
      if (bus.m_ready && bus.m_we)
        for (int b = 0; b < 4; b++)
          if (bus.m_wstrb[b]) mem[bus.m_addr[7:0]][8*b +: 8] <= bus.m_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_valid  = 1'b0; bus.i_addr  = '0;
    bus.d_rvalid = 1'b0; bus.d_raddr = '0;
    bus.d_wvalid = 1'b0; bus.d_waddr = '0; bus.d_wdata = '0; bus.d_wstrb = '0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    resetb = 1'b0;
    cyc(); cyc();
    resetb = 1'b1;
  endtask

  typedef struct {
    logic       pre_wb;
    logic       iv;
    logic       drv;
    logic       hit;
    logic       dwv;
    logic [4:0] exp;   // {i_gnt, d_rgnt, d_wgnt, m_ready, m_we}
    string      name;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic p, input logic iv, input logic drv, input logic h,
                     input logic dwv, input logic [4:0] e, input string n);
    vec_t v;
    v.pre_wb = p; v.iv = iv; v.drv = drv; v.hit = h; v.dwv = dwv; v.exp = e; v.name = n;
    vq.push_back(v);
  endtask

  // random-phase model state
  logic [31:0] mem_arch [0:255];
  logic        iact, dract, dwact;
  logic        mb_v;
  logic [29:0] mb_a;
  logic [31:0] mb_d;
  logic [3:0]  mb_s;
  logic        ip, dp;
  logic [31:0] ipd, dpd;
  int          iwait, drwait;
  logic [31:0] w;

  initial begin
    idle_inputs();
    resetb  = 1'b0;
    preload = 1'b1;
    cyc();
    preload = 1'b0;
    cyc();
    resetb = 1'b1;

    // reset state
    smp();
    chk("rst_wb_full", 64'(bus.wb_full), 64'h0);
    chk("rst_rresp", 64'({bus.i_rresp, bus.d_rresp}), 64'h0);
    chk("rst_outputs", 64'({bus.i_gnt, bus.d_rgnt, bus.d_wgnt, bus.m_ready, bus.m_we}), 64'h0);
    chk("rst_m_bus", 64'({bus.m_addr, bus.m_wstrb}), 64'h0);

    // single-cycle selection table
    add(0, 0, 0, 0, 0, 5'b00000, "v_idle");
    add(0, 1, 0, 0, 0, 5'b10010, "v_if");
    add(0, 0, 1, 0, 0, 5'b01010, "v_dr");
    add(0, 1, 1, 0, 0, 5'b01010, "v_dr_over_if");
    add(0, 0, 0, 0, 1, 5'b00100, "v_write_empty");
    add(0, 0, 1, 0, 1, 5'b01110, "v_read_and_write");
    add(1, 0, 0, 0, 0, 5'b00011, "v_drain");
    add(1, 1, 0, 0, 0, 5'b10010, "v_if_over_drain");
    add(1, 1, 0, 0, 1, 5'b00111, "v_pressure");
    add(1, 0, 1, 0, 0, 5'b01010, "v_dr_over_drain");
    add(1, 0, 1, 1, 0, 5'b00011, "v_hazard");
    add(1, 0, 1, 0, 1, 5'b01010, "v_dr_over_pressure");
    add(1, 1, 1, 1, 1, 5'b00111, "v_hazard_with_write");
    foreach (vq[k]) begin
      do_reset();
      if (vq[k].pre_wb) begin
        cyc();
        bus.d_wvalid = 1'b1; bus.d_waddr = 30'h30; bus.d_wdata = 32'h12345678; bus.d_wstrb = 4'hF;
        cyc();
        idle_inputs();
      end else begin
        cyc();
      end
      bus.i_valid  = vq[k].iv;  bus.i_addr  = 30'h90;
      bus.d_rvalid = vq[k].drv; bus.d_raddr = vq[k].hit ? 30'h30 : 30'h31;
      bus.d_wvalid = vq[k].dwv; bus.d_waddr = 30'h32; bus.d_wdata = 32'h0BADF00D; bus.d_wstrb = 4'hF;
      smp();
      chk(vq[k].name, 64'({bus.i_gnt, bus.d_rgnt, bus.d_wgnt, bus.m_ready, bus.m_we}), 64'(vq[k].exp));
      chk({vq[k].name, "_wb_full"}, 64'(bus.wb_full), 64'(vq[k].pre_wb));
      idle_inputs();
    end

    // idle fetch
    do_reset();
    cyc();
    bus.i_valid = 1'b1; bus.i_addr = 30'h10;
    smp();
    chk("fetch_gnt", 64'(bus.i_gnt), 64'h1);
    chk("fetch_m_addr", 64'(bus.m_addr), 64'h10);
    cyc();
    idle_inputs();
    smp();
    chk("fetch_rresp", 64'(bus.i_rresp), 64'h1);
    chk("fetch_rdata", 64'(bus.i_rdata), 64'hDEADBEEF);
    chk("fetch_no_d_rresp", 64'(bus.d_rresp), 64'h0);

    // posted write then read of the same word
    cyc();
    bus.d_wvalid = 1'b1; bus.d_waddr = 30'h20; bus.d_wdata = 32'h000000AA; bus.d_wstrb = 4'b0001;
    smp();
    chk("raw_wgnt", 64'(bus.d_wgnt), 64'h1);
    cyc();
    idle_inputs();
    bus.d_rvalid = 1'b1; bus.d_raddr = 30'h20;
    smp();
    chk("raw_drain", 64'({bus.m_ready, bus.m_we, bus.d_rgnt}), 64'b110);
    chk("raw_drain_addr", 64'({bus.m_addr, bus.m_wstrb}), 64'({30'h20, 4'b0001}));
    cyc();
    smp();
    chk("raw_rgnt", 64'({bus.d_rgnt, bus.m_we}), 64'b10);
    cyc();
    bus.d_rvalid = 1'b0;
    smp();
    w = init_word(32'h20);
    w[7:0] = 8'hAA;
    chk("raw_rresp", 64'(bus.d_rresp), 64'h1);
    chk("raw_lowbyte", 64'(bus.d_rdata[7:0]), 64'hAA);
    chk("raw_word", 64'(bus.d_rdata), 64'(w));

    // starvation bound with a continuous data read stream
    do_reset();
    cyc();
    bus.d_rvalid = 1'b1; bus.d_raddr = 30'h05;
    bus.i_valid  = 1'b1; bus.i_addr  = 30'h90;
    for (int k = 0; k < 10; k++) begin
      smp();
      chk($sformatf("starve_i_gnt_%0d", k), 64'(bus.i_gnt), 64'((k == 4) || (k == 9)));
      chk($sformatf("starve_d_rgnt_%0d", k), 64'(bus.d_rgnt), 64'(!((k == 4) || (k == 9))));
      cyc();
    end
    idle_inputs();

    // buffer pressure: back-to-back writes while fetch is requesting
    do_reset();
    cyc();
    bus.i_valid = 1'b1; bus.i_addr = 30'h90;
    for (int k = 0; k < 3; k++) begin
      bus.d_wvalid = 1'b1; bus.d_waddr = 30'(32'h40 + 4*k);
      bus.d_wdata = 32'h10000000 + k; bus.d_wstrb = 4'hF;
      smp();
      chk($sformatf("press_wgnt_%0d", k), 64'(bus.d_wgnt), 64'h1);
      if (k > 0) chk($sformatf("press_reload_%0d", k), 64'({bus.m_we, bus.i_gnt}), 64'b10);
      cyc();
    end
    idle_inputs();
    smp();
    chk("press_final_drain", 64'({bus.m_we, bus.m_addr}), 64'({1'b1, 30'h48}));
    chk("press_full_before", 64'(bus.wb_full), 64'h1);
    cyc();
    smp();
    chk("press_full_after", 64'(bus.wb_full), 64'h0);
    chk("press_mem40", 64'(mem[8'h40]), 64'h10000000);
    chk("press_mem44", 64'(mem[8'h44]), 64'h10000001);
    chk("press_mem48", 64'(mem[8'h48]), 64'h10000002);

    // simultaneous read and write with an empty buffer
    do_reset();
    cyc();
    bus.d_rvalid = 1'b1; bus.d_raddr = 30'h50;
    bus.d_wvalid = 1'b1; bus.d_waddr = 30'h60; bus.d_wdata = 32'h55; bus.d_wstrb = 4'hF;
    smp();
    chk("simul_grants", 64'({bus.d_rgnt, bus.d_wgnt, bus.m_we}), 64'b110);
    chk("simul_addr", 64'(bus.m_addr), 64'h50);
    cyc();
    idle_inputs();
    smp();
    chk("simul_rresp", 64'(bus.d_rresp), 64'h1);
    chk("simul_rdata", 64'(bus.d_rdata), 64'(init_word(32'h50)));

    // reset in the cycle after an instruction grant
    do_reset();
    cyc();
    bus.i_valid  = 1'b1; bus.i_addr  = 30'h10;
    bus.d_wvalid = 1'b1; bus.d_waddr = 30'h70; bus.d_wdata = 32'h77; bus.d_wstrb = 4'hF;
    smp();
    chk("rstmid_gnts", 64'({bus.i_gnt, bus.d_wgnt}), 64'b11);
    cyc();
    idle_inputs();
    resetb = 1'b0;
    smp();
    chk("rstmid_i_rresp", 64'(bus.i_rresp), 64'h0);
    chk("rstmid_wb_full", 64'(bus.wb_full), 64'h0);
    cyc();
    resetb = 1'b1;
    cyc();
    bus.i_valid = 1'b1; bus.i_addr = 30'h10;
    smp();
    chk("rstmid_regnt", 64'(bus.i_gnt), 64'h1);
    cyc();
    idle_inputs();
    smp();
    chk("rstmid_rdata", 64'({bus.i_rresp, bus.i_rdata}), 64'({1'b1, 32'hDEADBEEF}));
    chk("rstmid_discarded", 64'(mem[8'h70]), 64'(init_word(32'h70)));

    // randomized traffic against an architectural memory model
    do_reset();
    for (int i = 0; i < 256; i++) mem_arch[i] = mem[i];
    iact = 0; dract = 0; dwact = 0; mb_v = 0; ip = 0; dp = 0;
    ipd = '0; dpd = '0; mb_a = '0; mb_d = '0; mb_s = '0;
    iwait = 0; drwait = 0;
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if (!iact && ($urandom_range(0, 99) < 60)) begin
        iact = 1; bus.i_addr = 30'(32'h80 + $urandom_range(0, 7));
      end
      if (!dract && ($urandom_range(0, 99) < 40)) begin
        dract = 1; bus.d_raddr = 30'($urandom_range(0, 7));
      end
      if (!dwact && ($urandom_range(0, 99) < 35)) begin
        dwact = 1; bus.d_waddr = 30'($urandom_range(0, 7));
        bus.d_wdata = $urandom; bus.d_wstrb = 4'($urandom_range(1, 15));
      end
      bus.i_valid = iact; bus.d_rvalid = dract; bus.d_wvalid = dwact;
      smp();
      chk("rnd_i_rresp", 64'(bus.i_rresp), 64'(ip));
      if (ip) chk("rnd_i_rdata", 64'(bus.i_rdata), 64'(ipd));
      chk("rnd_d_rresp", 64'(bus.d_rresp), 64'(dp));
      if (dp) chk("rnd_d_rdata", 64'(bus.d_rdata), 64'(dpd));
      chk("rnd_one_read", 64'(bus.i_gnt && bus.d_rgnt), 64'h0);
      chk("rnd_gnt_unrequested", 64'({bus.i_gnt && !iact, bus.d_rgnt && !dract, bus.d_wgnt && !dwact}), 64'h0);
      chk("rnd_wb_full", 64'(bus.wb_full), 64'(mb_v));
      chk("rnd_busy", 64'(bus.m_ready), 64'(iact || dract || mb_v));
      if (dwact && !mb_v) chk("rnd_wgnt_empty", 64'(bus.d_wgnt), 64'h1);
      if (bus.m_ready && bus.m_we)
        chk("rnd_drain", 64'({mb_v, bus.m_addr, bus.m_wstrb}), 64'({1'b1, mb_a, mb_s}));
      if (bus.m_ready && bus.m_we) chk("rnd_drain_data", 64'(bus.m_wdata), 64'(mb_d));
      iwait  = (iact && !bus.i_gnt) ? iwait + 1 : 0;
      drwait = (dract && !bus.d_rgnt) ? drwait + 1 : 0;
      if (iact) chk("rnd_i_wait_bound", 64'(iwait <= MAXW + 1), 64'h1);
      if (dract) chk("rnd_dr_wait_bound", 64'(drwait <= 32), 64'h1);
      ip = bus.i_gnt;
      if (bus.i_gnt) ipd = mem_arch[bus.i_addr[7:0]];
      dp = bus.d_rgnt;
      if (bus.d_rgnt) dpd = mem_arch[bus.d_raddr[7:0]];
      if (bus.m_ready && bus.m_we) mb_v = 0;
      if (bus.d_wgnt) begin
        for (int b = 0; b < 4; b++)
          if (bus.d_wstrb[b]) mem_arch[bus.d_waddr[7:0]][8*b +: 8] = bus.d_wdata[8*b +: 8];
        mb_v = 1; mb_a = bus.d_waddr; mb_d = bus.d_wdata; mb_s = bus.d_wstrb;
      end
      if (bus.i_gnt) iact = 0;
      if (bus.d_rgnt) dract = 0;
      if (bus.d_wgnt) dwact = 0;
    end
    cyc();
    idle_inputs();
    smp();
    chk("rnd_last_i_rresp", 64'(bus.i_rresp), 64'(ip));
    if (ip) chk("rnd_last_i_rdata", 64'(bus.i_rdata), 64'(ipd));
    chk("rnd_last_d_rresp", 64'(bus.d_rresp), 64'(dp));
    if (dp) chk("rnd_last_d_rdata", 64'(bus.d_rdata), 64'(dpd));
    for (int k = 0; k < 5 && bus.wb_full; k++) begin
      cyc(); smp();
    end
    chk("rnd_drained", 64'(bus.wb_full), 64'h0);
    cyc(); smp();
    for (int a = 0; a < 8; a++)
      chk($sformatf("rnd_final_mem_%0d", a), 64'(mem[a]), 64'(mem_arch[a]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
